// File: rtl/de_port_arbiter.sv
// de_port_arbiter: round-robin sharing of the drawing-engine write port among
// four clients. The winner's address, byte enables and data are registered
// onto de_*, the downstream handshake is run, and a one-cycle c_ack goes back
// to the winner. A watchdog aborts a transfer that never sees de_ack.

// Per-client lane: request masking and the registered completion pulse.
module de_port_arbiter_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic en_i,
  input  logic sel_i,
  input  logic fin_i,
  output logic elig_o,
  output logic ack_o
);

  logic ack_q, ack_d;

  assign elig_o = req_i & en_i;
  assign ack_d  = fin_i & sel_i;
  assign ack_o  = ack_q;

  // Completion pulse: set on the finishing edge, cleared on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

endmodule

module de_port_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int NB_W    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          c_req,
  input  logic [4*ADDR_W-1:0] c_addr,
  input  logic [4*NB_W-1:0]   c_nbyte,
  input  logic [4*DATA_W-1:0] c_wdata,
  input  logic [3:0]          client_en,
  output logic [3:0]          c_ack,
  output logic                c_err,
  output logic                busy,
  output logic [1:0]          grant,
  output logic                de_req,
  input  logic                de_ack,
  output logic [ADDR_W-1:0]   de_addr,
  output logic [NB_W-1:0]     de_nbyte,
  output logic [DATA_W-1:0]   de_w_data
);

  localparam int NCLI = 4;
  // Watchdog disabled when TIMEOUT is 0; the counter never exceeds TIMEOUT-1.
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  // Flat client buses viewed as per-client packed arrays (same bit layout).
  logic [NCLI-1:0][ADDR_W-1:0] addr_v;
  logic [NCLI-1:0][NB_W-1:0]   nb_v;
  logic [NCLI-1:0][DATA_W-1:0] wd_v;

  assign addr_v = c_addr;
  assign nb_v   = c_nbyte;
  assign wd_v   = c_wdata;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          grant_q, grant_d;
  logic                de_req_q, de_req_d;
  logic                c_err_q, c_err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NB_W-1:0]     nb_q, nb_d;
  logic [DATA_W-1:0]   wd_q, wd_d;

  logic [NCLI-1:0]     elig;
  logic [NCLI-1:0]     sel_oh;
  logic                fin;
  logic                win_vld;
  logic [1:0]          win_idx;

  assign sel_oh = NCLI'(1) << grant_q;

  de_port_arbiter_lane u_lane [NCLI-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (c_req),
    .en_i   (client_en),
    .sel_i  (sel_oh),
    .fin_i  ({NCLI{fin}}),
    .elig_o (elig),
    .ack_o  (c_ack)
  );

  // Rotating priority: scan from the far end towards last+1 so the nearest
  // eligible client after the previous owner is the one left selected.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = NCLI; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state and datapath control for IDLE -> ISSUE -> DONE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    de_req_d = de_req_q;
    c_err_d  = 1'b0;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nb_d     = nb_q;
    wd_d     = wd_q;
    fin      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = ISSUE;
          grant_d  = win_idx;
          last_d   = win_idx;
          addr_d   = addr_v[win_idx];
          nb_d     = nb_v[win_idx];
          wd_d     = wd_v[win_idx];
          de_req_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ISSUE: begin
        // de_ack takes precedence over a simultaneous timeout.
        if (de_ack) begin
          fin      = 1'b1;
          de_req_d = 1'b0;
          state_d  = DONE;
        end else if (WD_EN && cnt_q == TO_LAST) begin
          fin      = 1'b1;
          c_err_d  = 1'b1;
          de_req_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        // Gap cycle lets downstream drop de_ack before the next de_req.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset puts client 0 at the head of the rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 2'd3;
      grant_q  <= 2'd0;
      de_req_q <= 1'b0;
      c_err_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      nb_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      de_req_q <= de_req_d;
      c_err_q  <= c_err_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nb_q     <= nb_d;
      wd_q     <= wd_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign de_req    = de_req_q;
  assign c_err     = c_err_q;
  assign de_addr   = addr_q;
  assign de_nbyte  = nb_q;
  assign de_w_data = wd_q;

endmodule

// File: tb/tb_de_port_arbiter.sv
// Bench for de_port_arbiter: table vectors, hand-written corner sequences and
// a randomized run against a transaction-level reference model.
module tb_de_port_arbiter;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]          c_req = '0;
  logic [3:0]          client_en = 4'hF;
  logic [3:0][AW-1:0]  c_addr;
  logic [3:0][NW-1:0]  c_nbyte;
  logic [3:0][DW-1:0]  c_wdata;
  logic                de_ack = 1'b0;
  logic [3:0]          c_ack;
  logic                c_err, busy, de_req;
  logic [1:0]          grant;
  logic [AW-1:0]       de_addr;
  logic [NW-1:0]       de_nbyte;
  logic [DW-1:0]       de_w_data;

  always #5 clk = ~clk;

  de_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NB_W(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .c_req(c_req), .c_addr(c_addr), .c_nbyte(c_nbyte),
    .c_wdata(c_wdata), .client_en(client_en), .c_ack(c_ack), .c_err(c_err),
    .busy(busy), .grant(grant), .de_req(de_req), .de_ack(de_ack),
    .de_addr(de_addr), .de_nbyte(de_nbyte), .de_w_data(de_w_data)
  );

  typedef struct packed {
    logic [3:0]    ack;
    logic          err;
    logic          busy;
    logic [1:0]    grant;
    logic          req;
    logic [AW-1:0] addr;
    logic [NW-1:0] nb;
    logic [DW-1:0] wd;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] en;
    logic       ack;
    logic [3:0] x_ack;
    logic       x_err;
    logic       x_busy;
    logic       x_req;
    logic [1:0] x_grant;
    int         src;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic obs_t observe();
    obs_t o;
    o.ack = c_ack; o.err = c_err; o.busy = busy; o.grant = grant; o.req = de_req;
    o.addr = de_addr; o.nb = de_nbyte; o.wd = de_w_data;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] en,
                     input logic a, input logic [3:0] xa, input logic xe,
                     input logic xb, input logic xr, input logic [1:0] xg, input int src);
    vec_t v;
    v.rst = r; v.req = rq; v.en = en; v.ack = a; v.x_ack = xa; v.x_err = xe;
    v.x_busy = xb; v.x_req = xr; v.x_grant = xg; v.src = src;
    tbl.push_back(v);
  endtask

  task automatic load_consts();
    for (int i = 0; i < 4; i++) begin
      c_addr[i]  = 18'h3F000 + 18'(i);
      c_nbyte[i] = 4'(i + 1);
      c_wdata[i] = 32'hA5A50000 + 32'(i);
    end
    c_addr[2] = 18'h00123; c_nbyte[2] = 4'hF; c_wdata[2] = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; c_req = '0; de_ack = 1'b0; client_en = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: one transfer at a time, winner = eligible client at the
  // smallest rotating distance after the previous owner.
  int   m_own, m_age, m_last;
  bit   m_cool;
  obs_t m_exp;

  task automatic model_reset();
    m_own = -1; m_age = 0; m_cool = 1'b0; m_last = 3; m_exp = '0;
  endtask

  task automatic model_step();
    int best, bd, d;
    m_exp.ack = '0;
    m_exp.err = 1'b0;
    if (m_own >= 0) begin
      if (de_ack || m_age == TO - 1) begin
        m_exp.ack = 4'(1 << m_own);
        m_exp.err = !de_ack;
        m_own = -1;
        m_cool = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      best = -1; bd = 99;
      for (int c = 0; c < 4; c++) begin
        d = (c - m_last + 3) % 4;
        if (c_req[c] && client_en[c] && d < bd) begin
          bd = d; best = c;
        end
      end
      if (best >= 0) begin
        m_own = best; m_last = best; m_age = 0;
        m_exp.grant = 2'(best);
        m_exp.addr = c_addr[best]; m_exp.nb = c_nbyte[best]; m_exp.wd = c_wdata[best];
      end
    end
    m_exp.req  = (m_own >= 0);
    m_exp.busy = (m_own >= 0) || m_cool;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int rr_seq[6];
    int mk_seq[4];
    int hi;
    bit seen;
    obs_t e;

    rr_seq = '{0, 1, 2, 3, 0, 1};
    mk_seq = '{3, 1, 3, 1};
    load_consts();

    // Reset, round-robin with immediate de_ack, masked clients, single client.
    add(0, 4'h0, 4'hF, 0, 4'h0, 0, 0, 0, 2'd0, -1);
    foreach (rr_seq[g]) begin
      add(1, 4'hF, 4'hF, 1, 4'h0, 0, 1, 1, 2'(rr_seq[g]), rr_seq[g]);
      add(1, 4'hF, 4'hF, 1, 4'(1 << rr_seq[g]), 0, 1, 0, 2'(rr_seq[g]), rr_seq[g]);
      add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 2'(rr_seq[g]), rr_seq[g]);
    end
    foreach (mk_seq[g]) begin
      add(1, 4'hF, 4'b1010, 1, 4'h0, 0, 1, 1, 2'(mk_seq[g]), mk_seq[g]);
      add(1, 4'hF, 4'b1010, 1, 4'(1 << mk_seq[g]), 0, 1, 0, 2'(mk_seq[g]), mk_seq[g]);
      add(1, 4'hF, 4'b1010, 1, 4'h0, 0, 0, 0, 2'(mk_seq[g]), mk_seq[g]);
    end
    add(0, 4'h0, 4'hF, 0, 4'h0, 0, 0, 0, 2'd0, -1);
    add(1, 4'b0100, 4'hF, 0, 4'h0, 0, 1, 1, 2'd2, 2);
    add(1, 4'b0100, 4'hF, 0, 4'h0, 0, 1, 1, 2'd2, 2);
    add(1, 4'b0100, 4'hF, 1, 4'b0100, 0, 1, 0, 2'd2, 2);
    add(1, 4'h0, 4'hF, 0, 4'h0, 0, 0, 0, 2'd2, 2);
    add(1, 4'h0, 4'hF, 0, 4'h0, 0, 0, 0, 2'd2, 2);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; c_req = tbl[i].req; client_en = tbl[i].en; de_ack = tbl[i].ack;
      @(posedge clk); #1;
      e = '0;
      e.ack = tbl[i].x_ack; e.err = tbl[i].x_err; e.busy = tbl[i].x_busy;
      e.grant = tbl[i].x_grant; e.req = tbl[i].x_req;
      if (tbl[i].src >= 0) begin
        e.addr = c_addr[tbl[i].src]; e.nb = c_nbyte[tbl[i].src]; e.wd = c_wdata[tbl[i].src];
      end
      check($sformatf("vec%0d", i), observe(), e);
    end

    // Watchdog: de_req high for exactly TO cycles, then an error completion.
    do_reset();
    c_req = 4'b0001;
    hi = 0; seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk); #1;
      if (de_req) hi++;
      if (c_ack != 4'h0) seen = 1'b1;
    end
    chk("to_ack_seen", 64'(seen), 64'd1);
    chk("to_req_cycles", 64'(hi), 64'(TO));
    chk("to_ack_err", 64'({c_ack, c_err, busy}), 64'({4'b0001, 1'b1, 1'b1}));
    @(negedge clk); c_req = '0;
    @(posedge clk); #1;
    chk("to_busy_drop", 64'({busy, c_ack, c_err, de_req}), 64'd0);

    // de_ack on the very cycle the watchdog would fire: clean completion.
    do_reset();
    c_req = 4'b0001;
    @(posedge clk); #1;
    chk("tie_start", 64'(de_req), 64'd1);
    for (int k = 0; k < TO - 1; k++) @(posedge clk);
    @(negedge clk); de_ack = 1'b1;
    @(posedge clk); #1;
    chk("tie_ack", 64'({c_ack, c_err}), 64'({4'b0001, 1'b0}));
    @(negedge clk); de_ack = 1'b0; c_req = '0;

    // Asynchronous reset in ISSUE, then client 0 first again.
    do_reset();
    c_req = 4'b0010;
    @(posedge clk); #1;
    chk("mid_issue", 64'({de_req, busy, grant}), 64'({1'b1, 1'b1, 2'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", 64'({de_req, busy, c_ack, c_err, grant, de_addr}), 64'd0);
    @(negedge clk); rst_n = 1'b1; c_req = 4'hF;
    @(posedge clk); #1;
    chk("mid_prio", 64'({de_req, grant}), 64'({1'b1, 2'd0}));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      c_req = 4'($urandom);
      client_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      de_ack = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 4; i++) begin
        c_addr[i] = 18'($urandom); c_nbyte[i] = 4'($urandom); c_wdata[i] = $urandom;
      end
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rand%0d", cyc), observe(), m_exp);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
